// File: rtl/lfsr_period_ctrl_if.sv
// Command/status and LFSR hookup bundle for lfsr_period_ctrl.
// The controller takes the slave side; the host plus LFSR model take the master side.
interface lfsr_period_ctrl_if #(
   parameter int NB_DATA  = 8,
   parameter int NB_COUNT = 16
);
   logic                i_start;
   logic                i_abort;
   logic [NB_DATA-1:0]  i_seed;
   logic [NB_DATA-1:0]  i_lfsr;
   logic [NB_DATA-1:0]  o_seed;
   logic                o_soft_reset;
   logic                o_valid;
   logic                o_busy;
   logic                o_done;
   logic [NB_COUNT-1:0] o_period;
   logic                o_lock;
   logic                o_error;

   modport master (
      output i_start, i_abort, i_seed, i_lfsr,
      input  o_seed, o_soft_reset, o_valid, o_busy, o_done, o_period, o_lock, o_error
   );

   modport slave (
      input  i_start, i_abort, i_seed, i_lfsr,
      output o_seed, o_soft_reset, o_valid, o_busy, o_done, o_period, o_lock, o_error
   );
endinterface

// File: rtl/lfsr_period_ctrl.sv
// Period-measurement sequencer for an lfsr_galois instance: seeds it, steps it
// until its output returns to the captured reference, and reports period/lock/error.
module lfsr_period_ctrl #(
   parameter int NB_DATA         = 8,
   parameter int NB_COUNT        = 16,
   parameter int EXPECTED_PERIOD = 255,
   parameter int MAX_STEPS       = 300
) (
   input  logic                 clk,
   input  logic                 i_rst,
   lfsr_period_ctrl_if.slave    bus
);

   localparam logic [NB_COUNT-1:0] MAX_C = NB_COUNT'(MAX_STEPS);
   localparam logic [NB_COUNT-1:0] EXP_C = NB_COUNT'(EXPECTED_PERIOD);

   typedef enum logic [2:0] {IDLE, LOAD, CAPTURE, RUN, DONE} state_t;

   state_t              state_reg;
   logic [NB_DATA-1:0]  seed_reg;
   logic [NB_DATA-1:0]  ref_reg;
   logic [NB_COUNT-1:0] count_reg;
   logic [NB_COUNT-1:0] period_reg;
   logic                lock_reg;
   logic                error_reg;
   logic                done_reg;
   logic                busy_reg;

   logic zero_hit;
   logic match_hit;
   logic timeout_hit;
   logic run_exit;

   // Exit conditions are evaluated on the current LFSR output, so the step that
   // would move the LFSR off the reference is never issued.
   always_comb begin
      zero_hit    = (bus.i_lfsr == '0);
      match_hit   = (count_reg != '0) && (bus.i_lfsr == ref_reg);
      timeout_hit = (count_reg == MAX_C);
      run_exit    = zero_hit || match_hit || timeout_hit;
   end

   assign bus.o_valid      = (state_reg == RUN)  && !bus.i_abort && !run_exit;
   assign bus.o_soft_reset = (state_reg == LOAD) && !bus.i_abort;
   assign bus.o_seed       = seed_reg;
   assign bus.o_busy       = busy_reg;
   assign bus.o_done       = done_reg;
   assign bus.o_period     = period_reg;
   assign bus.o_lock       = lock_reg;
   assign bus.o_error      = error_reg;

   always_ff @(posedge clk or negedge i_rst) begin
      if (!i_rst) begin
         state_reg  <= IDLE;
         seed_reg   <= '0;
         ref_reg    <= '0;
         count_reg  <= '0;
         period_reg <= '0;
         lock_reg   <= 1'b0;
         error_reg  <= 1'b0;
         done_reg   <= 1'b0;
         busy_reg   <= 1'b0;
      end else begin
         done_reg <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (bus.i_start && !bus.i_abort) begin
                  seed_reg   <= bus.i_seed;
                  period_reg <= '0;
                  lock_reg   <= 1'b0;
                  error_reg  <= 1'b0;
                  busy_reg   <= 1'b1;
                  state_reg  <= LOAD;
               end
            end
            LOAD, CAPTURE, RUN: begin
               if (bus.i_abort) begin
                  period_reg <= '0;
                  lock_reg   <= 1'b0;
                  error_reg  <= 1'b0;
                  busy_reg   <= 1'b0;
                  state_reg  <= IDLE;
               end else if (state_reg == LOAD) begin
                  state_reg <= CAPTURE;
               end else if (state_reg == CAPTURE) begin
                  ref_reg   <= bus.i_lfsr;
                  count_reg <= '0;
                  state_reg <= RUN;
               end else if (run_exit) begin
                  // Verdict is registered on entry to DONE so it is valid alongside o_done.
                  if (zero_hit) begin
                     period_reg <= count_reg;
                     error_reg  <= 1'b1;
                     lock_reg   <= 1'b0;
                  end else if (match_hit) begin
                     period_reg <= count_reg;
                     error_reg  <= 1'b0;
                     lock_reg   <= (count_reg == EXP_C);
                  end else begin
                     period_reg <= MAX_C;
                     error_reg  <= 1'b1;
                     lock_reg   <= 1'b0;
                  end
                  done_reg  <= 1'b1;
                  busy_reg  <= 1'b0;
                  state_reg <= DONE;
               end else begin
                  count_reg <= count_reg + NB_COUNT'(1);
               end
            end
            DONE: begin
               state_reg <= IDLE;
            end
            default: begin
               state_reg <= IDLE;
            end
         endcase
      end
   end

endmodule
